pipe_multiplier: RTL

Parametrised, fully pipelined integer multiplier with per-operation signed/unsigned mode, a valid/ready handshake on both sides, and a tag carried alongside each operation. It sustains one multiply per cycle with back-pressure. It is the next-generation multiply unit for the ALU datapath and replaces the fixed 8-bit, start/done-only multiplier.

---
 rtl/pipe_multiplier.sv | 82 ++++++++
 1 files changed

// File: rtl/pipe_multiplier.sv
// Fully pipelined signed/unsigned multiplier: a registered partial-product stage
// followed by a registered binary adder tree, with valid/tag sideband and global stall.
module pipe_multiplier #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic [TAG_W-1:0]     out_tag,
   output logic                 busy
);

   localparam int LVL   = $clog2(WIDTH);
   localparam int PW    = 2 * WIDTH;
   localparam int NODES = 2 * WIDTH - 1;

   // Every tree level lives in one flat array; level l starts at this offset
   // and holds WIDTH >> l rows, so the final sum lands in the last entry.
   function automatic int lvl_off(input int l);
      return (2 * WIDTH) - ((2 * WIDTH) >> l);
   endfunction

   logic [PW-1:0]    r_tree [0:NODES-1];
   logic [LVL:0]     r_vld;
   logic [TAG_W-1:0] r_tag  [0:LVL];

   logic             w_adv;
   logic [PW-1:0]    w_a_ext;
   logic [PW-1:0]    w_row;
   logic [PW-1:0]    w_pp   [0:WIDTH-1];

   assign w_adv     = !r_vld[LVL] || out_ready;
   assign in_ready  = w_adv;
   assign out_valid = r_vld[LVL];
   assign result    = r_tree[NODES-1];
   assign out_tag   = r_tag[LVL];
   assign busy      = |r_vld;

   // The multiplier MSB carries weight -2^(WIDTH-1) in signed mode, so that row is negated.
   always_comb begin
      w_a_ext = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
      w_row   = '0;
      w_pp    = '{default: '0};
      for (int i = 0; i < WIDTH; i++) begin
         w_row   = b[i] ? (w_a_ext << i) : '0;
         w_pp[i] = (is_signed && (i == WIDTH - 1)) ? (-w_row) : w_row;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld  <= '0;
         r_tag  <= '{default: '0};
         r_tree <= '{default: '0};
      end else if (w_adv) begin
         r_vld    <= {r_vld[LVL-1:0], in_valid};
         r_tag[0] <= in_tag;
         for (int l = 1; l <= LVL; l++) begin
            r_tag[l] <= r_tag[l-1];
         end
         for (int i = 0; i < WIDTH; i++) begin
            r_tree[i] <= w_pp[i];
         end
         for (int l = 1; l <= LVL; l++) begin
            for (int i = 0; i < (WIDTH >> l); i++) begin
               r_tree[lvl_off(l) + i] <= r_tree[lvl_off(l-1) + 2*i]
                                       + r_tree[lvl_off(l-1) + 2*i + 1];
            end
         end
      end
   end

endmodule
